// File: rtl/regfile_wb_buffer_pkg.sv
// Shared defaults for the register-file writeback buffer and its lookup helper.
package regfile_wb_buffer_pkg;

  localparam int DBITS_DEFAULT = 32;
  localparam int ABITS_DEFAULT = 4;
  localparam int DEPTH_DEFAULT = 4;

  // Pointer width for a power-of-two ring of the given depth.
  function automatic int ptr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wb_match.sv
// Priority lookup over the pending writeback ring.
// Returns the newest occupied entry whose index matches the read index.
module wb_match
  import regfile_wb_buffer_pkg::*;
#(
  parameter int DBITS = DBITS_DEFAULT,
  parameter int ABITS = ABITS_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int PBITS = ptr_bits(DEPTH)
) (
  input  logic [ABITS-1:0] inds  [DEPTH],
  input  logic [DBITS-1:0] datas [DEPTH],
  input  logic [PBITS-1:0] head,
  input  logic [PBITS:0]   occupied,
  input  logic [ABITS-1:0] rd_ind,
  output logic             hit,
  output logic [DBITS-1:0] data
);

  // Walk from oldest to newest; a later match overwrites an earlier one,
  // so the newest pending write for the index wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (((PBITS+1)'(k) < occupied) && (inds[head + PBITS'(k)] == rd_ind)) begin
        hit  = 1'b1;
        data = datas[head + PBITS'(k)];
      end
    end
  end

endmodule

// File: rtl/regfile_wb_buffer.sv
// In-order writeback buffer in front of the register file's single write port,
// with newest-value forwarding for two read ports.
module regfile_wb_buffer
  import regfile_wb_buffer_pkg::*;
#(
  parameter int DBITS = DBITS_DEFAULT,
  parameter int ABITS = ABITS_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inValid,
  output logic             inReady,
  input  logic [ABITS-1:0] inInd,
  input  logic [DBITS-1:0] inData,
  input  logic             hold,
  output logic             wrtEn,
  output logic [ABITS-1:0] wrtInd,
  output logic [DBITS-1:0] dOut,
  input  logic [ABITS-1:0] rdInd0,
  input  logic [ABITS-1:0] rdInd1,
  output logic             fwdHit0,
  output logic             fwdHit1,
  output logic [DBITS-1:0] fwdData0,
  output logic [DBITS-1:0] fwdData1,
  output logic [ABITS:0]   count,
  output logic             empty
);

  localparam int PBITS = ptr_bits(DEPTH);

  logic [ABITS-1:0] ind_q  [DEPTH];
  logic [DBITS-1:0] data_q [DEPTH];
  logic [PBITS-1:0] head;
  logic [PBITS-1:0] tail;
  logic [PBITS:0]   cnt;
  logic             push;
  logic             pop;

  // Handshake: a request transfers on a rising edge where inValid && inReady.
  // inReady depends only on occupancy, so a full buffer refuses even when the
  // head drains on the same edge.
  assign inReady = (cnt != (PBITS+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign push    = inValid && inReady;
  assign wrtEn   = !empty && !hold;
  assign pop     = wrtEn;
  assign wrtInd  = empty ? '0 : ind_q[head];
  assign dOut    = empty ? '0 : data_q[head];
  assign count   = (ABITS+1)'(cnt);

  // Entry storage carries no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      ind_q[tail]  <= inInd;
      data_q[tail] <= inData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + PBITS'(1);
      if (pop)  head <= head + PBITS'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + (PBITS+1)'(1);
        2'b01:   cnt <= cnt - (PBITS+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  wb_match #(.DBITS(DBITS), .ABITS(ABITS), .DEPTH(DEPTH), .PBITS(PBITS)) u_match0 (
    .inds     (ind_q),
    .datas    (data_q),
    .head     (head),
    .occupied (cnt),
    .rd_ind   (rdInd0),
    .hit      (fwdHit0),
    .data     (fwdData0)
  );

  wb_match #(.DBITS(DBITS), .ABITS(ABITS), .DEPTH(DEPTH), .PBITS(PBITS)) u_match1 (
    .inds     (ind_q),
    .datas    (data_q),
    .head     (head),
    .occupied (cnt),
    .rd_ind   (rdInd1),
    .hit      (fwdHit1),
    .data     (fwdData1)
  );

endmodule

// File: tb/tb_regfile_wb_buffer.sv
// Self-checking bench for regfile_wb_buffer: directed scenarios then random
// traffic, compared against a queue-based reference of pending writes.
module tb_regfile_wb_buffer;

  localparam int DBITS = 32;
  localparam int ABITS = 4;
  localparam int DEPTH = 4;
  localparam int NREGS = 2**ABITS;

  logic             clk;
  logic             rst_n;
  logic             inValid;
  logic             inReady;
  logic [ABITS-1:0] inInd;
  logic [DBITS-1:0] inData;
  logic             hold;
  logic             wrtEn;
  logic [ABITS-1:0] wrtInd;
  logic [DBITS-1:0] dOut;
  logic [ABITS-1:0] rdInd0;
  logic [ABITS-1:0] rdInd1;
  logic             fwdHit0;
  logic             fwdHit1;
  logic [DBITS-1:0] fwdData0;
  logic [DBITS-1:0] fwdData1;
  logic [ABITS:0]   count;
  logic             empty;

  typedef struct packed {
    logic [ABITS-1:0] ind;
    logic [DBITS-1:0] data;
  } entry_t;

  entry_t           exp_q[$];
  logic [DBITS-1:0] exp_rf [NREGS];
  logic [DBITS-1:0] dut_rf [NREGS];
  int               checks;
  int               errors;

  regfile_wb_buffer #(.DBITS(DBITS), .ABITS(ABITS), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inValid  (inValid),
    .inReady  (inReady),
    .inInd    (inInd),
    .inData   (inData),
    .hold     (hold),
    .wrtEn    (wrtEn),
    .wrtInd   (wrtInd),
    .dOut     (dOut),
    .rdInd0   (rdInd0),
    .rdInd1   (rdInd1),
    .fwdHit0  (fwdHit0),
    .fwdHit1  (fwdHit1),
    .fwdData0 (fwdData0),
    .fwdData1 (fwdData1),
    .count    (count),
    .empty    (empty)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Newest pending write to ri, searching the reference queue back to front.
  task automatic fwd_model(input logic [ABITS-1:0] ri, output logic hit,
                           output logic [DBITS-1:0] d);
    hit = 1'b0;
    d   = '0;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].ind == ri) begin
        hit = 1'b1;
        d   = exp_q[i].data;
        break;
      end
    end
  endtask

  task automatic check_all();
    logic             h;
    logic [DBITS-1:0] d;
    int               n;
    n = exp_q.size();
    chk("count", count, n);
    chk("empty", empty, n == 0);
    chk("inReady", inReady, n != DEPTH);
    chk("wrtEn", wrtEn, (n != 0) && !hold);
    if (n != 0) begin
      chk("wrtInd", wrtInd, exp_q[0].ind);
      chk("dOut", dOut, exp_q[0].data);
    end else begin
      chk("wrtInd", wrtInd, 0);
      chk("dOut", dOut, 0);
    end
    fwd_model(rdInd0, h, d);
    chk("fwdHit0", fwdHit0, h);
    chk("fwdData0", fwdData0, d);
    fwd_model(rdInd1, h, d);
    chk("fwdHit1", fwdHit1, h);
    chk("fwdData1", fwdData1, d);
  endtask

  // ---------------- driver / scoreboard step ----------------
  // Check outputs mid-cycle, then apply the edge to both DUT log and reference.
  task automatic cycle();
    logic   w;
    entry_t wr;
    bit     do_push;
    bit     do_pop;
    @(negedge clk);
    check_all();
    w  = wrtEn;
    wr = entry_t'({wrtInd, dOut});
    @(posedge clk);
    if (w) dut_rf[wr.ind] = wr.data;
    do_pop  = (exp_q.size() != 0) && !hold;
    do_push = inValid && (exp_q.size() != DEPTH);
    if (do_pop) begin
      exp_rf[exp_q[0].ind] = exp_q[0].data;
      void'(exp_q.pop_front());
    end
    if (do_push) exp_q.push_back(entry_t'({inInd, inData}));
    #1;
  endtask

  task automatic drive(input logic v, input logic [ABITS-1:0] ind, input logic [DBITS-1:0] data);
    inValid = v;
    inInd   = ind;
    inData  = data;
  endtask

  task automatic drain(input string tag);
    inValid = 1'b0;
    hold    = 1'b0;
    for (int i = 0; i < 3 * DEPTH && exp_q.size() != 0; i++) cycle();
    cycle();
    chk(tag, empty, 1'b1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < NREGS; i++) begin
      exp_rf[i] = '0;
      dut_rf[i] = '0;
    end
    rst_n  = 1'b0;
    hold   = 1'b1;
    rdInd0 = '0;
    rdInd1 = 4'd3;
    drive(1'b0, '0, '0);

    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    hold  = 1'b0;
    cycle();
    cycle();

    // Single request, immediate drain
    drive(1'b1, 4'd3, 32'hDEADBEEF);
    rdInd0 = 4'd3;
    cycle();
    drive(1'b0, '0, '0);
    chk("single_wrtEn", wrtEn, 1'b1);
    chk("single_wrtInd", wrtInd, 4'd3);
    chk("single_dOut", dOut, 32'hDEADBEEF);
    chk("single_fwdHit0", fwdHit0, 1'b1);
    chk("single_fwdData0", fwdData0, 32'hDEADBEEF);
    cycle();
    chk("single_empty", empty, 1'b1);
    chk("single_fwdHit0_after", fwdHit0, 1'b0);
    cycle();

    // Fill under hold, refuse a fifth push, then drain with interleaved pushes
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, ABITS'(i), DBITS'(i * 16));
      rdInd0 = ABITS'(i);
      cycle();
    end
    chk("fill_count", count, 4);
    chk("fill_inReady", inReady, 1'b0);
    drive(1'b1, 4'd9, 32'h99);
    cycle();
    chk("fill_refused_count", count, 4);
    hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ABITS'(6 + i), DBITS'(32'h60 + i));
      rdInd1 = ABITS'(6 + i);
      cycle();
    end
    drain("fill_drained");
    chk("fill_rf4", dut_rf[4], 32'h40);

    // Duplicate index: newest forwarded, writes retire in order
    hold = 1'b1;
    drive(1'b1, 4'd5, 32'hA);
    cycle();
    drive(1'b1, 4'd5, 32'hB);
    cycle();
    drive(1'b0, '0, '0);
    rdInd1 = 4'd5;
    cycle();
    chk("dup_fwdHit1", fwdHit1, 1'b1);
    chk("dup_fwdData1", fwdData1, 32'hB);
    drain("dup_drained");
    chk("dup_rf5", dut_rf[5], 32'hB);

    // Simultaneous push and pop at count 2
    hold = 1'b1;
    drive(1'b1, 4'd7, 32'h71);
    cycle();
    drive(1'b1, 4'd8, 32'h81);
    cycle();
    hold = 1'b0;
    drive(1'b1, 4'd9, 32'h91);
    cycle();
    chk("simul_count", count, 2);
    chk("simul_head", wrtInd, 4'd8);
    drain("simul_drained");

    // Reset while three entries are draining
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ABITS'(10 + i), DBITS'(32'hC0 + i));
      cycle();
    end
    drive(1'b0, '0, '0);
    hold = 1'b0;
    @(negedge clk);
    check_all();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_wrtEn", wrtEn, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_inReady", inReady, 1'b1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    chk("rst_no_stale_rf10", dut_rf[10], 32'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), ABITS'($urandom_range(0, NREGS - 1)),
            $urandom);
      hold   = ($urandom_range(0, 3) == 0);
      rdInd0 = ABITS'($urandom_range(0, NREGS - 1));
      rdInd1 = ABITS'($urandom_range(0, NREGS - 1));
      cycle();
    end
    drain("rand_drained");

    for (int i = 0; i < NREGS; i++) begin
      chk($sformatf("rf[%0d]", i), dut_rf[i], exp_rf[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
